// File: rtl/fp_widen_pipe_unit.sv
// rtl/fp_widen_pipe_unit.sv - pipelined FP16/FP32 -> FP32/FP64 widening converter
// Decode and normalise before stage 0, carry fields down the pipe, pack from the last stage.
module fp_widen_pipe_unit #(
  parameter int XLEN       = 64,
  parameter int NUM_STAGES = 2,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [1:0]           src_fmt_i,
  input  logic [XLEN-1:0]      operand_a_i,
  input  logic [TAG_WIDTH-1:0] tag_id_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [XLEN-1:0]      result_o,
  output logic [4:0]           status_o,
  output logic [TAG_WIDTH-1:0] tag_id_o,
  output logic                 busy_o
);

  localparam logic [1:0] CLS_ZERO = 2'd0;
  localparam logic [1:0] CLS_FIN  = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  typedef struct packed {
    logic                 sign;
    logic                 dst_d;
    logic [1:0]           cls;
    logic [10:0]          exp;
    logic [22:0]          mnt;
    logic                 nv;
    logic [TAG_WIDTH-1:0] tag;
  } pl_t;

  logic        w_src_h;
  logic        w_dst_d;
  logic        w_boxed;
  logic        w_sign;
  logic        w_exp_max;
  logic        w_exp_zero;
  logic        w_mnt_nz;
  logic [7:0]  w_exp_in;
  logic [22:0] w_mnt_in;
  logic [10:0] w_delta;
  logic [4:0]  w_lz;
  logic [4:0]  w_shamt;
  pl_t         w_in_pl;

  // Half mantissas are left-aligned into the 23-bit field so one lz/shift path serves both sources.
  always_comb begin
    w_src_h = ~src_fmt_i[1];
    w_dst_d = (src_fmt_i != 2'b00);
    if (w_src_h) begin
      w_boxed   = &operand_a_i[XLEN-1:16];
      w_sign    = operand_a_i[15];
      w_exp_in  = {3'b000, operand_a_i[14:10]};
      w_exp_max = &operand_a_i[14:10];
      w_mnt_in  = {operand_a_i[9:0], 13'd0};
      w_delta   = w_dst_d ? 11'd1008 : 11'd112;
    end else begin
      w_boxed   = &operand_a_i[XLEN-1:32];
      w_sign    = operand_a_i[31];
      w_exp_in  = operand_a_i[30:23];
      w_exp_max = &operand_a_i[30:23];
      w_mnt_in  = operand_a_i[22:0];
      w_delta   = 11'd896;
    end
    w_exp_zero = (w_exp_in == 8'd0);
    w_mnt_nz   = |w_mnt_in;
  end

  always_comb begin
    w_lz = 5'd0;
    for (int i = 0; i < 23; i++) begin
      if (w_mnt_in[i]) w_lz = 5'(22 - i);
    end
  end

  assign w_shamt = w_lz + 5'd1;

  always_comb begin
    w_in_pl       = '0;
    w_in_pl.sign  = w_sign;
    w_in_pl.dst_d = w_dst_d;
    w_in_pl.cls   = CLS_FIN;
    w_in_pl.exp   = {3'b000, w_exp_in} + w_delta;
    w_in_pl.mnt   = w_mnt_in;
    w_in_pl.nv    = 1'b0;
    w_in_pl.tag   = tag_id_i;
    if (src_fmt_i == 2'b11) begin
      w_in_pl.cls = CLS_NAN;
      w_in_pl.nv  = 1'b1;
    end else if (!w_boxed) begin
      w_in_pl.cls = CLS_NAN;
    end else if (w_exp_max) begin
      w_in_pl.cls = w_mnt_nz ? CLS_NAN : CLS_INF;
      w_in_pl.nv  = w_mnt_nz & ~w_mnt_in[22];
    end else if (w_exp_zero) begin
      if (!w_mnt_nz) begin
        w_in_pl.cls = CLS_ZERO;
      end else begin
        w_in_pl.exp = w_delta - {6'd0, w_lz};
        w_in_pl.mnt = w_mnt_in << w_shamt;
      end
    end
  end

  logic [NUM_STAGES-1:0] r_vld;
  logic [NUM_STAGES-1:0] w_rdy;
  logic [NUM_STAGES-1:0] w_src_vld;
  logic                  w_chain;
  pl_t                   r_pl      [NUM_STAGES];
  pl_t                   w_src_pl  [NUM_STAGES];

  // A stage can load if it, or any stage below it, has a hole, or the consumer is draining.
  always_comb begin
    w_chain = out_ready_i;
    w_rdy   = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      w_chain  = w_chain | ~r_vld[k];
      w_rdy[k] = w_chain;
    end
  end

  always_comb begin
    w_src_vld    = '0;
    w_src_vld[0] = in_valid_i;
    for (int k = 0; k < NUM_STAGES; k++) w_src_pl[k] = w_in_pl;
    for (int k = 1; k < NUM_STAGES; k++) begin
      w_src_vld[k] = r_vld[k-1];
      w_src_pl[k]  = r_pl[k-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld <= '0;
      for (int k = 0; k < NUM_STAGES; k++) r_pl[k] <= '0;
    end else if (flush_i) begin
      r_vld <= '0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (w_rdy[k]) begin
          r_vld[k] <= w_src_vld[k];
          if (w_src_vld[k]) r_pl[k] <= w_src_pl[k];
        end
      end
    end
  end

  pl_t            w_last;
  logic [XLEN-1:0] w_res;

  assign w_last = r_pl[NUM_STAGES-1];

  always_comb begin
    w_res = '0;
    if (w_last.dst_d) begin
      case (w_last.cls)
        CLS_ZERO: w_res = {w_last.sign, 63'd0};
        CLS_INF:  w_res = {w_last.sign, 11'h7FF, 52'd0};
        CLS_NAN:  w_res = 64'h7FF8_0000_0000_0000;
        default:  w_res = {w_last.sign, w_last.exp, w_last.mnt, 29'd0};
      endcase
    end else begin
      case (w_last.cls)
        CLS_ZERO: w_res = {32'hFFFF_FFFF, w_last.sign, 31'd0};
        CLS_INF:  w_res = {32'hFFFF_FFFF, w_last.sign, 8'hFF, 23'd0};
        CLS_NAN:  w_res = {32'hFFFF_FFFF, 32'h7FC0_0000};
        default:  w_res = {32'hFFFF_FFFF, w_last.sign, w_last.exp[7:0], w_last.mnt};
      endcase
    end
  end

  assign in_ready_o  = w_rdy[0];
  assign out_valid_o = r_vld[NUM_STAGES-1];
  assign busy_o      = |r_vld;
  assign result_o    = out_valid_o ? w_res : '0;
  assign status_o    = out_valid_o ? {w_last.nv, 4'b0000} : 5'd0;
  assign tag_id_o    = out_valid_o ? w_last.tag : '0;

endmodule
